// File: rtl/segre_mm_responder.sv
// -----------------------------------------------------------------------------
// segre_mm_responder
//
// Main-memory end of the MMU line-fill / writeback protocol. Holds an internal
// array of LANE_SIZE-bit lines and serves one line request at a time. Every
// request completes a fixed LATENCY cycles after it is accepted.
//
// A write commits to the array at its acceptance edge. A read fetches its line
// near the end of the wait period. Requests are sampled only in IDLE. Because
// every transaction passes through RESP before returning to IDLE, a request
// held through the completion edge is not serviced a second time.
//
// Ports
//   clk_i         in   1          clock, all state on rising edge
//   rst_i         in   1          asynchronous active-high reset (array not reset)
//   mm_rd_i       in   1          line read (fill) request, level
//   mm_wr_i       in   1          line write (writeback) request, level, wins over read
//   mm_addr_i     in   ADDR_SIZE  byte address of the line
//   mm_wr_data_i  in   LANE_SIZE  writeback line
//   mm_rdy_o      out  1          one-cycle completion pulse
//   mm_rd_data_o  out  LANE_SIZE  read line, valid with mm_rdy_o, held until next read
//   mm_busy_o     out  1          high from acceptance through the mm_rdy_o cycle
// -----------------------------------------------------------------------------
module segre_mm_responder #(
   parameter int LATENCY          = 10,   // 2..255
   parameter int MEM_LINES        = 1024, // power of 2
   parameter int LANE_SIZE        = 128,
   parameter int ADDR_SIZE        = 32,
   parameter int DCACHE_BYTE_SIZE = 4     // log2 of the line size in bytes
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mm_rd_i,
   input  logic                 mm_wr_i,
   input  logic [ADDR_SIZE-1:0] mm_addr_i,
   input  logic [LANE_SIZE-1:0] mm_wr_data_i,
   output logic                 mm_rdy_o,
   output logic [LANE_SIZE-1:0] mm_rd_data_o,
   output logic                 mm_busy_o
);

   localparam int         IDX_W    = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              state;
   logic [7:0]          count;
   logic [IDX_W-1:0]    req_index;
   logic                op_read;

   logic [IDX_W-1:0]    line_index;
   logic [IDX_W-1:0]    rd_index;
   logic                accept_wr;

   logic [LANE_SIZE-1:0] mem [MEM_LINES];
   logic [LANE_SIZE-1:0] mem_q;

   // Byte offset bits and upper (aliasing) bits do not select a line.
   logic unused_addr;
   assign unused_addr = ^mm_addr_i;

   assign line_index = mm_addr_i[DCACHE_BYTE_SIZE +: IDX_W];
   assign accept_wr  = (state == IDLE) && mm_wr_i;

   // The read port follows the incoming address while idle and the latched
   // index afterwards. This way mem_q already holds the requested line in the
   // first WAIT cycle, which is what LATENCY=2 needs.
   assign rd_index = (state == IDLE) ? line_index : req_index;

   // Line array: no reset, so it maps onto block RAM with a registered read.
   always_ff @(posedge clk_i) begin
      if (accept_wr) begin
         mem[line_index] <= mm_wr_data_i;
      end
      mem_q <= mem[rd_index];
   end

   // Control FSM; all outputs are registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         count        <= '0;
         req_index    <= '0;
         op_read      <= 1'b0;
         mm_rdy_o     <= 1'b0;
         mm_busy_o    <= 1'b0;
         mm_rd_data_o <= '0;
      end else begin
         mm_rdy_o <= 1'b0;
         case (state)
            IDLE: begin
               if (mm_wr_i || mm_rd_i) begin
                  req_index <= line_index;
                  op_read   <= !mm_wr_i;   // writeback wins a simultaneous request
                  count     <= CNT_LOAD;
                  mm_busy_o <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  if (op_read) begin
                     mm_rd_data_o <= mem_q;
                  end
                  mm_rdy_o <= 1'b1;
                  state    <= RESP;
               end else begin
                  count <= count - 8'd1;
               end
            end
            RESP: begin
               mm_busy_o <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_segre_mm_responder.sv
// -----------------------------------------------------------------------------
// Testbench for segre_mm_responder. It drives two instances:
//   dut  : LATENCY=10, MEM_LINES=1024
//   dut2 : LATENCY=2,  MEM_LINES=16
// Expected values come from a line-array model indexed by (addr/16) % lines
// and from the fixed latency rule.
// -----------------------------------------------------------------------------
module tb_segre_mm_responder;

   localparam int LAT   = 10;
   localparam int LINES = 1024;
   localparam int LAT2  = 2;
   localparam int LINES2 = 16;

   logic         clk;
   logic         rst;

   logic         rd, wr;
   logic [31:0]  addr;
   logic [127:0] wdata;
   logic         rdy, busy;
   logic [127:0] rdata;

   logic         rd2, wr2;
   logic [31:0]  addr2;
   logic [127:0] wdata2;
   logic         rdy2, busy2;
   logic [127:0] rdata2;

   int total = 0;
   int bad   = 0;

   logic [127:0] ref_mem  [LINES];
   logic [127:0] ref_mem2 [LINES2];
   logic [127:0] ref_rdata;
   logic [127:0] ref_rdata2;
   int           rdy2_pulses = 0;

   segre_mm_responder #(.LATENCY(LAT), .MEM_LINES(LINES)) dut (
      .clk_i(clk), .rst_i(rst), .mm_rd_i(rd), .mm_wr_i(wr),
      .mm_addr_i(addr), .mm_wr_data_i(wdata), .mm_rdy_o(rdy),
      .mm_rd_data_o(rdata), .mm_busy_o(busy)
   );

   segre_mm_responder #(.LATENCY(LAT2), .MEM_LINES(LINES2)) dut2 (
      .clk_i(clk), .rst_i(rst), .mm_rd_i(rd2), .mm_wr_i(wr2),
      .mm_addr_i(addr2), .mm_wr_data_i(wdata2), .mm_rdy_o(rdy2),
      .mm_rd_data_o(rdata2), .mm_busy_o(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (rdy2 === 1'b1) rdy2_pulses++;

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 32'd16) % LINES);
   endfunction

   function automatic int idx2_of(input logic [31:0] a);
      return int'((a / 32'd16) % LINES2);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Issues one request on dut at the current negedge (cycle 0). It drops the
   // request at the negedge of the rdy cycle and then waits one more cycle.
   task automatic run_req(input bit r, input bit w, input logic [31:0] a,
                          input logic [127:0] d, output int lat,
                          output logic [127:0] q, output bit busy_ok,
                          output bit after_ok);
      rd = r; wr = w; addr = a; wdata = d;
      busy_ok = (busy === 1'b0);
      lat = -1;
      q = 'x;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 0;
         if (rdy === 1'b1) begin
            lat = c;
            q = rdata;
            break;
         end
      end
      rd = 0; wr = 0;
      @(negedge clk);
      after_ok = (rdy === 1'b0) && (busy === 1'b0);
   endtask

   // Same for dut2, but the request stays high through the completion edge
   // and is dropped just after it.
   task automatic req2(input bit r, input bit w, input logic [31:0] a,
                       input logic [127:0] d, output int lat,
                       output logic [127:0] q, output bit after_ok);
      rd2 = r; wr2 = w; addr2 = a; wdata2 = d;
      lat = -1;
      q = 'x;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (rdy2 === 1'b1) begin
            lat = c;
            q = rdata2;
            break;
         end
      end
      @(posedge clk);
      #1;
      rd2 = 0; wr2 = 0;
      @(negedge clk);
      after_ok = (rdy2 === 1'b0) && (busy2 === 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_rdata = '0;
      ref_rdata2 = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (rdy !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle cycle %0d: rdy=%b busy=%b, want 0 0", c, rdy, busy);
         end
      end
      total++;
      if (rdata !== 128'd0) begin
         bad++;
         $display("FAIL reset_rdata: got %h want 0", rdata);
      end
      total++;
      if (rdy2 !== 1'b0 || busy2 !== 1'b0 || rdata2 !== 128'd0) begin
         bad++;
         $display("FAIL reset_dut2: rdy=%b busy=%b rdata=%h want 0 0 0", rdy2, busy2, rdata2);
      end
      $display("txn reset done");
   endtask

   // Checks one dut transaction against the model and updates the model.
   task automatic check_txn(input string name, input bit r, input bit w,
                            input logic [31:0] a, input logic [127:0] d);
      int lat;
      logic [127:0] q;
      logic [127:0] exp_q;
      bit bok, aok;
      if (w) ref_mem[idx_of(a)] = d;
      else ref_rdata = ref_mem[idx_of(a)];
      exp_q = ref_rdata;
      run_req(r, w, a, d, lat, q, bok, aok);
      $display("txn %s %s addr=%h lat=%0d rdata=%h", name, w ? "wr" : "rd", a, lat, q);
      total++;
      if (lat != LAT) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
      end
      total++;
      if (q !== exp_q) begin
         bad++;
         $display("FAIL %s_rdata: got %h want %h", name, q, exp_q);
      end
      total++;
      if (!bok || !aok) begin
         bad++;
         $display("FAIL %s_busy_rdy_shape: busy_ok=%0d after_ok=%0d want 1 1", name, bok, aok);
      end
   endtask

   task automatic test_write_read();
      check_txn("wr40", 0, 1, 32'h40, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D);
      check_txn("rd4C", 1, 0, 32'h4C, 128'd0);
   endtask

   task automatic test_rd_wr_both();
      int pulses[$];
      logic [127:0] d;
      logic [127:0] q_first;
      logic [127:0] q_second;
      d = rnd128();
      ref_mem[idx_of(32'h80)] = d;
      q_first = 'x;
      q_second = 'x;
      rd = 1; wr = 1; addr = 32'h80; wdata = d;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            pulses.push_back(c);
            if (pulses.size() == 1) begin
               q_first = rdata;
               wr = 0;
            end else begin
               q_second = rdata;
               rd = 0;
               break;
            end
         end
      end
      rd = 0; wr = 0;
      @(negedge clk);
      $display("txn rdwr addr=80 pulses=%0d first=%0d", pulses.size(),
               pulses.size() > 0 ? pulses[0] : -1);
      total++;
      if (pulses.size() != 2) begin
         bad++;
         $display("FAIL rdwr_pulse_count: got %0d want 2", pulses.size());
      end else begin
         total++;
         if (pulses[0] != LAT || pulses[1] != 2 * LAT + 1) begin
            bad++;
            $display("FAIL rdwr_pulse_cycles: got %0d,%0d want %0d,%0d",
                     pulses[0], pulses[1], LAT, 2 * LAT + 1);
         end
      end
      total++;
      if (q_first !== ref_rdata) begin
         bad++;
         $display("FAIL rdwr_write_keeps_rdata: got %h want %h", q_first, ref_rdata);
      end
      ref_rdata = d;
      total++;
      if (q_second !== d) begin
         bad++;
         $display("FAIL rdwr_read_data: got %h want %h", q_second, d);
      end
   endtask

   task automatic test_alias();
      check_txn("alias_wr0", 0, 1, 32'h0, rnd128());
      check_txn("alias_rd4000", 1, 0, 32'h4000, 128'd0);
   endtask

   task automatic test_reset_mid();
      int seen;
      logic [127:0] d;
      // A read aborted at cycle 5 must never complete.
      rd = 1; addr = 32'h40;
      repeat (5) @(negedge clk);
      rst = 1; rd = 0;
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (rdy === 1'b1) seen++;
      end
      rst = 0;
      ref_rdata = '0;
      repeat (15) begin
         @(negedge clk);
         if (rdy === 1'b1) seen++;
      end
      $display("txn reset_mid_read rdy_seen=%0d", seen);
      total++;
      if (seen != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_no_rdy: rdy_seen=%0d busy=%b want 0 0", seen, busy);
      end
      total++;
      if (rdata !== 128'd0) begin
         bad++;
         $display("FAIL reset_mid_rdata: got %h want 0", rdata);
      end
      check_txn("after_reset_rd", 1, 0, 32'h44, 128'd0);
      // A write is committed at acceptance, so it survives an abort.
      d = rnd128();
      ref_mem[idx_of(32'h1230)] = d;
      wr = 1; addr = 32'h1230; wdata = d;
      repeat (3) @(negedge clk);
      rst = 1; wr = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      ref_rdata = '0;
      ref_rdata2 = '0;
      @(negedge clk);
      check_txn("after_reset_wr_rd", 1, 0, 32'h1238, 128'd0);
   endtask

   task automatic test_random();
      logic [31:0] written[$];
      logic [31:0] a;
      for (int i = 0; i < 24; i++) begin
         if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
            a = $urandom_range(0, 31) * 16 + $urandom_range(0, 15) + ($urandom_range(0, 7) << 14);
            written.push_back(a);
            check_txn("rand", 0, 1, a, rnd128());
         end else begin
            a = written[$urandom_range(0, written.size() - 1)];
            a = (a & ~32'h3F_C00F) | 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 15)) << 14);
            check_txn("rand", 1, 0, a, 128'd0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int start_pulses;
      int nreq;
      logic [127:0] q;
      logic [127:0] d;
      logic [31:0] a;
      bit aok;
      start_pulses = rdy2_pulses;
      nreq = 0;
      for (int i = 0; i < 4; i++) begin
         a = 32'(i * 16) + 32'($urandom_range(0, 15));
         d = rnd128();
         ref_mem2[idx2_of(a)] = d;
         req2(0, 1, a, d, lat, q, aok);
         nreq++;
         $display("txn b2b wr addr=%h lat=%0d", a, lat);
         total++;
         if (lat != LAT2 || q !== ref_rdata2 || !aok) begin
            bad++;
            $display("FAIL b2b_write: lat=%0d rdata=%h after_ok=%0d want %0d %h 1",
                     lat, q, aok, LAT2, ref_rdata2);
         end
      end
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3) * 256);
         ref_rdata2 = ref_mem2[idx2_of(a)];
         req2(1, 0, a, 128'd0, lat, q, aok);
         nreq++;
         $display("txn b2b rd addr=%h lat=%0d rdata=%h", a, lat, q);
         total++;
         if (lat != LAT2 || q !== ref_rdata2 || !aok) begin
            bad++;
            $display("FAIL b2b_read: lat=%0d rdata=%h after_ok=%0d want %0d %h 1",
                     lat, q, aok, LAT2, ref_rdata2);
         end
      end
      repeat (6) @(negedge clk);
      total++;
      if (rdy2_pulses - start_pulses != nreq) begin
         bad++;
         $display("FAIL b2b_pulse_count: got %0d want %0d", rdy2_pulses - start_pulses, nreq);
      end
   endtask

   initial begin
      rst = 1; rd = 0; wr = 0; addr = '0; wdata = '0;
      rd2 = 0; wr2 = 0; addr2 = '0; wdata2 = '0;
      ref_rdata = '0;
      ref_rdata2 = '0;
      for (int i = 0; i < LINES; i++) ref_mem[i] = 'x;
      for (int i = 0; i < LINES2; i++) ref_mem2[i] = 'x;
      repeat (3) @(negedge clk);
      test_reset();
      test_write_read();
      test_rd_wr_both();
      test_alias();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
